dds_sweep_ctrl: RTL and testbench
=================================

Name: dds_sweep_ctrl

Overview:
Sequencer that drives the frequency and phase control words of one DDS channel through a programmable frequency sweep. It sits between the key/config logic and the DDS core's Fword/Pword/Reset_n inputs. It issues a one-cycle phase-alignment reset to the DDS at sweep start. Two instances serve the two AD9767 channels.

Parameters:
FW_W, 32, frequency word width
PW_W, 12, phase word width
DWELL_W, 24, dwell counter width

Ports:
CLK_125M  in  1  system clock, 125 MHz
Reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle sweep start request
stop_req  in  1  one-cycle abort request
mode  in  2  0 single up-sweep, 1 sawtooth repeat, 2 triangle repeat, 3 treated as 0
f_start  in  FW_W  first frequency word
f_stop  in  FW_W  last frequency word
f_step  in  FW_W  increment per step
dwell  in  DWELL_W  cycles each word is held
p_offset  in  PW_W  phase word applied during sweep
Fword_out  out  FW_W  to DDS Fword
Pword_out  out  PW_W  to DDS Pword
dds_rst_n  out  1  to DDS Reset_n, low for one cycle at sweep load
upd  out  1  one-cycle pulse on every Fword_out change
busy  out  1  high while sweeping
sweep_done  out  1  one-cycle pulse at mode-0 completion

Behaviour:
- Reset_n is asynchronous, active-low; clock is CLK_125M. Reset values: Fword_out=0, Pword_out=0, dds_rst_n=1, upd=0, busy=0, sweep_done=0, state=IDLE, direction=up.
- States: IDLE, LOAD, DWELL.
- IDLE: on start (and no stop_req), latch all config inputs, go to LOAD, busy=1. A start while busy is ignored. If stop_req and start arrive in the same cycle, stop wins and start is ignored.
- LOAD (one cycle):
  - Fword_out=f_start, Pword_out=p_offset.
  - dds_rst_n=0 and upd=1 for this one edge.
  - Load dwell counter with D=max(dwell,1), then go to DWELL.
  - Latency: start sampled at edge k; new word and dds_rst_n low at edge k+1.
- DWELL: counter decrements. Each Fword_out value stays visible exactly D cycles. On the edge where the count hits its end, compute the next word and update Fword_out in that same edge, pulse upd, and reload the counter.
- Step arithmetic uses FW_W+1 bits, so there is never a silent overflow.
  - Up: next=cur+f_step; if next>=f_stop, next=f_stop.
  - Down (mode 2 only): next=cur-f_step; if next<=f_start or it borrows, next=f_start.
- End of the f_stop dwell:
  - Mode 0: go to IDLE, sweep_done=1 for one cycle, busy=0 on the same edge, words held.
  - Mode 1: next word=f_start.
  - Mode 2: direction flips to down. At the end of the f_start dwell while going down, direction flips to up.
- Degenerate config (f_step=0 or f_start>=f_stop): Fword_out holds f_start.
  - Mode 0: completes after one dwell period.
  - Modes 1/2: run until stop_req. upd does not pulse when the value is unchanged.
- stop_req in LOAD/DWELL: go to IDLE next edge, busy=0, Fword_out/Pword_out hold last values, no sweep_done.
- Reset mid-sweep: all outputs return to reset values immediately.

Optional Feature:
DDS_SWEEP_PHASE_STEP_EN
- Defined: adds input p_step[PW_W-1:0], latched at start. Pword_out advances by p_step on every frequency-word update; it wraps modulo 2^PW_W and is reset to p_offset in LOAD.
- Undefined: port absent, Pword_out constant p_offset during the sweep.

Test Plan:
1. mode0, f_start=100, f_stop=400, f_step=100, dwell=3 -> Fword_out 100,200,300,400, each 3 cycles; 4 upd pulses; dds_rst_n low 1 cycle at load; sweep_done 1 cycle after 400's third cycle, busy low with it.
2. Clamp and overflow:
   - f_start=100, f_stop=350, f_step=100 -> 100,200,300,350 then done.
   - f_start=0xFFFFFF00, f_stop=0xFFFFFFFF, f_step=0x80 -> 0xFFFFFF00, 0xFFFFFF80, 0xFFFFFFFF, no wrap to low values.
3. mode1 with config of test 1 -> ...,400,100,200...; stop_req while at 200 -> busy=0 next edge, Fword_out stays 200, no sweep_done.
4. mode2 with config of test 1 -> 100,200,300,400,300,200,100,200,... indefinitely.
5. Edge handshakes:
   - dwell=0 -> each word held 1 cycle.
   - start while busy -> ignored.
   - start and stop_req same cycle in IDLE -> stays IDLE.
   - f_step=0 in mode0 -> single dwell at f_start, then done.
6. Reset_n low mid-sweep -> Fword_out=0, busy=0, dds_rst_n=1 asynchronously; a new start after release runs test 1 correctly.

Source files
------------

// File: rtl/dds_sweep_ctrl_if.sv
// Control/status bundle between the key/config logic and the DDS sweep sequencer.
// DDS_SWEEP_PHASE_STEP_EN adds the p_step phase-increment field.
interface dds_sweep_ctrl_if #(
    parameter int FW_W    = 32,
    parameter int PW_W    = 12,
    parameter int DWELL_W = 24
);
    logic               start;
    logic               stop_req;
    logic [1:0]         mode;
    logic [FW_W-1:0]    f_start;
    logic [FW_W-1:0]    f_stop;
    logic [FW_W-1:0]    f_step;
    logic [DWELL_W-1:0] dwell;
    logic [PW_W-1:0]    p_offset;
`ifdef DDS_SWEEP_PHASE_STEP_EN
    logic [PW_W-1:0]    p_step;
`endif
    logic [FW_W-1:0]    Fword_out;
    logic [PW_W-1:0]    Pword_out;
    logic               dds_rst_n;
    logic               upd;
    logic               busy;
    logic               sweep_done;

    modport master (
`ifdef DDS_SWEEP_PHASE_STEP_EN
        output p_step,
`endif
        output start, stop_req, mode,
        output f_start, f_stop, f_step,
        output dwell, p_offset,
        input  Fword_out, Pword_out,
        input  dds_rst_n, upd,
        input  busy, sweep_done
    );

    modport slave (
`ifdef DDS_SWEEP_PHASE_STEP_EN
        input  p_step,
`endif
        input  start, stop_req, mode,
        input  f_start, f_stop, f_step,
        input  dwell, p_offset,
        output Fword_out, Pword_out,
        output dds_rst_n, upd,
        output busy, sweep_done
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for one DDS channel (Fword/Pword/Reset_n driver).
// Optional DDS_SWEEP_PHASE_STEP_EN: Pword_out advances by p_step per word update.
module dds_sweep_ctrl #(
    parameter int FW_W    = 32,
    parameter int PW_W    = 12,
    parameter int DWELL_W = 24
) (
    input  logic            CLK_125M,
    input  logic            Reset_n,
    dds_sweep_ctrl_if.slave sw
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DWELL = 2'd2;

    logic [1:0]         state;
    logic               dir_up;
    logic [1:0]         mode_q;
    logic [FW_W-1:0]    fs_q;
    logic [FW_W-1:0]    fe_q;
    logic [FW_W-1:0]    st_q;
    logic [DWELL_W-1:0] d_q;
    logic [DWELL_W-1:0] cnt;
    logic [PW_W-1:0]    po_q;
    logic               degen_q;
`ifdef DDS_SWEEP_PHASE_STEP_EN
    logic [PW_W-1:0]    ps_q;
`endif

    logic [FW_W-1:0]    fw_q;
    logic [PW_W-1:0]    pw_q;
    logic               rstn_q;
    logic               upd_q;
    logic               busy_q;
    logic               done_q;

    logic [FW_W:0]      sum;
    logic [FW_W:0]      diff;
    logic [FW_W-1:0]    nxt_up;
    logic [FW_W-1:0]    nxt_dn;
    logic [FW_W-1:0]    nword;
    logic               adv;
    logic               fin;
    logic               dir_nx;
    logic               rep;

    assign sw.Fword_out  = fw_q;
    assign sw.Pword_out  = pw_q;
    assign sw.dds_rst_n  = rstn_q;
    assign sw.upd        = upd_q;
    assign sw.busy       = busy_q;
    assign sw.sweep_done = done_q;

    assign rep = (mode_q == 2'd1) || (mode_q == 2'd2);

    // One extra bit so a step past the top or below zero is caught, never wrapped
    always_comb begin
        sum    = {1'b0, fw_q} + {1'b0, st_q};
        diff   = {1'b0, fw_q} - {1'b0, st_q};
        nxt_up = (sum >= {1'b0, fe_q}) ? fe_q : sum[FW_W-1:0];
        nxt_dn = (diff[FW_W] || (diff[FW_W-1:0] <= fs_q))
               ? fs_q : diff[FW_W-1:0];
    end

    always_comb begin
        adv    = 1'b0;
        fin    = 1'b0;
        dir_nx = dir_up;
        nword  = fw_q;
        if (degen_q) begin
            fin = !rep;
        end else if (dir_up) begin
            if (fw_q != fe_q) begin
                adv   = 1'b1;
                nword = nxt_up;
            end else if (mode_q == 2'd1) begin
                adv   = 1'b1;
                nword = fs_q;
            end else if (mode_q == 2'd2) begin
                adv    = 1'b1;
                dir_nx = 1'b0;
                nword  = nxt_dn;
            end else begin
                fin = 1'b1;
            end
        end else begin
            adv = 1'b1;
            if (fw_q == fs_q) begin
                dir_nx = 1'b1;
                nword  = nxt_up;
            end else begin
                nword = nxt_dn;
            end
        end
    end

    always_ff @(posedge CLK_125M or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            dir_up  <= 1'b1;
            mode_q  <= '0;
            fs_q    <= '0;
            fe_q    <= '0;
            st_q    <= '0;
            d_q     <= '0;
            cnt     <= '0;
            po_q    <= '0;
            degen_q <= 1'b0;
`ifdef DDS_SWEEP_PHASE_STEP_EN
            ps_q    <= '0;
`endif
            fw_q    <= '0;
            pw_q    <= '0;
            rstn_q  <= 1'b1;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            upd_q  <= 1'b0;
            rstn_q <= 1'b1;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sw.start && !sw.stop_req) begin
                        mode_q  <= sw.mode;
                        fs_q    <= sw.f_start;
                        fe_q    <= sw.f_stop;
                        st_q    <= sw.f_step;
                        d_q     <= (sw.dwell == '0) ? DWELL_W'(1) : sw.dwell;
                        po_q    <= sw.p_offset;
                        degen_q <= (sw.f_step == '0) ||
                                   (sw.f_start >= sw.f_stop);
`ifdef DDS_SWEEP_PHASE_STEP_EN
                        ps_q    <= sw.p_step;
`endif
                        busy_q  <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (sw.stop_req) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        fw_q   <= fs_q;
                        pw_q   <= po_q;
                        rstn_q <= 1'b0;
                        upd_q  <= 1'b1;
                        cnt    <= d_q;
                        dir_up <= 1'b1;
                        state  <= DWELL;
                    end
                end
                DWELL: begin
                    if (sw.stop_req) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt != DWELL_W'(1)) begin
                        cnt <= cnt - DWELL_W'(1);
                    end else begin
                        cnt    <= d_q;
                        dir_up <= dir_nx;
                        if (adv) begin
                            fw_q  <= nword;
                            upd_q <= 1'b1;
`ifdef DDS_SWEEP_PHASE_STEP_EN
                            pw_q  <= pw_q + ps_q;
`endif
                        end
                        if (fin) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl with a word-list sweep model checked every cycle.
module tb_dds_sweep_ctrl;
    localparam int FW_W    = 32;
    localparam int PW_W    = 12;
    localparam int DWELL_W = 24;

    logic CLK_125M = 1'b0;
    logic Reset_n  = 1'b0;

    dds_sweep_ctrl_if #(.FW_W(FW_W), .PW_W(PW_W), .DWELL_W(DWELL_W)) sw ();

    dds_sweep_ctrl #(.FW_W(FW_W), .PW_W(PW_W), .DWELL_W(DWELL_W)) dut (
        .CLK_125M (CLK_125M),
        .Reset_n  (Reset_n),
        .sw       (sw)
    );

    always #4 CLK_125M = ~CLK_125M;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Model: the sweep is the list of words it visits; each is held D cycles,
    // the list either ends (mode 0/3) or wraps back to its first entry.
    longint seq[$];
    int     loop_i;
    int     idx;
    int     cnt;
    int     dq;
    logic [PW_W-1:0] cfg_po;
    logic [FW_W-1:0] m_fw   = '0;
    logic [PW_W-1:0] m_pw   = '0;
    bit     m_busy = 0, m_upd = 0, m_rstn = 1, m_done = 0, m_load = 0;

    task automatic build_seq();
        longint fs, fe, st, w;
        int md;
        bit degen;
        fs = longint'(sw.f_start);
        fe = longint'(sw.f_stop);
        st = longint'(sw.f_step);
        md = int'(sw.mode);
        degen = (st == 0) || (fs >= fe);
        seq.delete();
        seq.push_back(fs);
        if (!degen) begin
            w = fs;
            while (w < fe) begin
                w = (w + st >= fe) ? fe : w + st;
                seq.push_back(w);
            end
        end
        if (md == 2 && !degen) begin
            w = fe;
            while (w - st > fs) begin
                w = w - st;
                seq.push_back(w);
            end
        end
        loop_i = (md == 1 || md == 2) ? 0 : -1;
        dq     = (sw.dwell == 0) ? 1 : int'(sw.dwell);
        cfg_po = sw.p_offset;
    endtask

    task automatic model_reset();
        m_fw = '0; m_pw = '0; m_busy = 0; m_upd = 0;
        m_rstn = 1; m_done = 0; m_load = 0;
    endtask

    task automatic model_step();
        m_upd = 0; m_rstn = 1; m_done = 0;
        if (m_load) begin
            m_load = 0;
            if (sw.stop_req) m_busy = 0;
            else begin
                m_fw = seq[0][FW_W-1:0];
                m_pw = cfg_po;
                m_upd = 1; m_rstn = 0;
                idx = 0; cnt = 0;
            end
        end else if (m_busy) begin
            if (sw.stop_req) m_busy = 0;
            else begin
                cnt++;
                if (cnt == dq) begin
                    cnt = 0;
                    idx++;
                    if (idx == seq.size()) begin
                        if (loop_i < 0) begin
                            m_done = 1; m_busy = 0; idx--;
                        end else idx = loop_i;
                    end
                    if (m_busy && seq[idx][FW_W-1:0] != m_fw) begin
                        m_fw = seq[idx][FW_W-1:0];
                        m_upd = 1;
                    end
                end
            end
        end else if (sw.start && !sw.stop_req) begin
            build_seq();
            m_busy = 1;
            m_load = 1;
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK_125M or negedge Reset_n);
            if (!Reset_n) model_reset();
            else model_step();
        end
    end

    longint rec[$];
    int     rec_cyc[$];
    int     cyc = 0, rstn_lo = 0, done_cnt = 0, done_cyc = 0;

    initial begin
        forever begin
            @(negedge CLK_125M);
            cyc++;
            chk("fword", sw.Fword_out, m_fw);
            chk("pword", sw.Pword_out, m_pw);
            chk("busy", sw.busy, m_busy);
            chk("upd", sw.upd, m_upd);
            chk("dds_rst_n", sw.dds_rst_n, m_rstn);
            chk("sweep_done", sw.sweep_done, m_done);
            if (sw.upd === 1'b1) begin
                rec.push_back(longint'(sw.Fword_out));
                rec_cyc.push_back(cyc);
            end
            if (sw.dds_rst_n === 1'b0) rstn_lo++;
            if (sw.sweep_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    longint exp_q[$];

    task automatic clr();
        rec.delete(); rec_cyc.delete(); exp_q.delete();
        rstn_lo = 0; done_cnt = 0; done_cyc = 0;
    endtask

    task automatic chk_rec(input string nm, input bit exact);
        if (exact) chk({nm, "_count"}, rec.size(), exp_q.size());
        else chk({nm, "_count"}, rec.size() >= exp_q.size(), 1);
        foreach (exp_q[i])
            if (i < rec.size()) chk(nm, rec[i], exp_q[i]);
    endtask

    task automatic run_start(input int md, input longint fs, input longint fe,
                             input longint st, input int dw, input int po);
        @(negedge CLK_125M); #1;
        sw.mode = 2'(md);
        sw.f_start = FW_W'(fs); sw.f_stop = FW_W'(fe); sw.f_step = FW_W'(st);
        sw.dwell = DWELL_W'(dw); sw.p_offset = PW_W'(po);
        sw.start = 1'b1;
        @(negedge CLK_125M); #1;
        sw.start = 1'b0;
    endtask

    task automatic pulse_stop();
        sw.stop_req = 1'b1;
        @(negedge CLK_125M); #1;
        sw.stop_req = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge CLK_125M); #1;
            if (done_cnt > 0) break;
        end
        if (i == budget) chk({nm, "_timeout"}, 1, 0);
    endtask

    task automatic wait_rec(input string nm, input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge CLK_125M); #1;
            if (rec.size() >= n) break;
        end
        if (i == budget) chk({nm, "_timeout"}, 1, 0);
    endtask

    task automatic test1(input string nm);
        clr();
        run_start(0, 100, 400, 100, 3, 'h123);
        wait_done(nm, 100);
        for (int v = 100; v <= 400; v += 100) exp_q.push_back(v);
        chk_rec(nm, 1);
        chk({nm, "_rstn_low_cycles"}, rstn_lo, 1);
        chk({nm, "_done_pulses"}, done_cnt, 1);
        if (rec_cyc.size() == 4) begin
            for (int i = 0; i < 3; i++)
                chk({nm, "_hold"}, rec_cyc[i+1] - rec_cyc[i], 3);
            chk({nm, "_last_hold"}, done_cyc - rec_cyc[3], 3);
        end
        chk({nm, "_busy_after"}, sw.busy, 0);
        chk({nm, "_pword"}, sw.Pword_out, 'h123);
    endtask

    int tri_v[9] = '{100, 200, 300, 400, 300, 200, 100, 200, 300};

    initial begin
        sw.start = 0; sw.stop_req = 0; sw.mode = 0;
        sw.f_start = 0; sw.f_stop = 0; sw.f_step = 0;
        sw.dwell = 0; sw.p_offset = 0;
        repeat (3) @(negedge CLK_125M);
        #1;
        chk("rst_fword", sw.Fword_out, 0);
        chk("rst_busy", sw.busy, 0);
        chk("rst_dds_rst_n", sw.dds_rst_n, 1);
        Reset_n = 1'b1;

        test1("t1");

        clr();
        run_start(3, 100, 350, 100, 2, 5);
        wait_done("t2a", 100);
        exp_q.push_back(100); exp_q.push_back(200);
        exp_q.push_back(300); exp_q.push_back(350);
        chk_rec("t2a", 1);

        clr();
        run_start(0, 'hFFFF_FF00, 'hFFFF_FFFF, 'h80, 2, 7);
        wait_done("t2b", 100);
        exp_q.push_back('hFFFF_FF00); exp_q.push_back('hFFFF_FF80);
        exp_q.push_back('hFFFF_FFFF);
        chk_rec("t2b", 1);

        clr();
        run_start(1, 100, 400, 100, 3, 9);
        wait_rec("t3", 6, 100);
        pulse_stop();
        chk("t3_busy", sw.busy, 0);
        chk("t3_fword", sw.Fword_out, 200);
        for (int v = 100; v <= 400; v += 100) exp_q.push_back(v);
        exp_q.push_back(100); exp_q.push_back(200);
        repeat (4) @(negedge CLK_125M);
        #1;
        chk_rec("t3", 1);
        chk("t3_no_done", done_cnt, 0);

        clr();
        run_start(2, 100, 400, 100, 3, 0);
        wait_rec("t4", 9, 100);
        pulse_stop();
        foreach (tri_v[i]) exp_q.push_back(tri_v[i]);
        chk_rec("t4", 0);

        clr();
        run_start(0, 100, 400, 100, 0, 0);
        wait_done("t5a", 50);
        for (int v = 100; v <= 400; v += 100) exp_q.push_back(v);
        chk_rec("t5a", 1);
        if (rec_cyc.size() == 4)
            chk("t5a_span", done_cyc - rec_cyc[0], 4);

        clr();
        run_start(0, 100, 400, 100, 3, 0);
        repeat (2) @(negedge CLK_125M);
        run_start(1, 5, 50, 1, 1, 0);
        wait_done("t5b", 100);
        for (int v = 100; v <= 400; v += 100) exp_q.push_back(v);
        chk_rec("t5b", 1);

        clr();
        @(negedge CLK_125M); #1;
        sw.start = 1'b1; sw.stop_req = 1'b1;
        @(negedge CLK_125M); #1;
        sw.start = 1'b0; sw.stop_req = 1'b0;
        repeat (3) @(negedge CLK_125M);
        #1;
        chk("t5c_busy", sw.busy, 0);
        chk("t5c_no_upd", rec.size(), 0);

        clr();
        run_start(0, 100, 400, 0, 3, 0);
        wait_done("t5d", 50);
        exp_q.push_back(100);
        chk_rec("t5d", 1);
        if (rec_cyc.size() == 1)
            chk("t5d_hold", done_cyc - rec_cyc[0], 3);

        clr();
        run_start(1, 100, 100, 50, 2, 0);
        repeat (10) @(negedge CLK_125M);
        #1;
        pulse_stop();
        exp_q.push_back(100);
        chk_rec("t5e_degen_rep", 1);

        clr();
        run_start(0, 100, 400, 100, 3, 'h55);
        wait_rec("t6", 2, 50);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("t6_fword", sw.Fword_out, 0);
        chk("t6_busy", sw.busy, 0);
        chk("t6_dds_rst_n", sw.dds_rst_n, 1);
        chk("t6_pword", sw.Pword_out, 0);
        @(negedge CLK_125M); #1;
        Reset_n = 1'b1;
        test1("t6_rerun");

        repeat (2) @(negedge CLK_125M);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
